bpu_dyn: RTL and testbench
==========================

# bpu_dyn

Parametrised dynamic branch prediction unit for the IF stage. It is the next generation of the static predictor. It keeps the decode-based target computation for JAL and B-type instructions. It adds a table of 2-bit saturating counters (bimodal BHT) for conditional branches, updated from EX, and a return-address stack (RAS) for JALR returns. A mode parameter can fall back to static backward-taken/forward-not-taken (BTFN) prediction.

## Interface
- BHT_ENTRIES, 64: number of 2-bit counters; power of two, 4..1024.
- RAS_DEPTH, 4: return-address stack entries; power of two, 2..16.
- PRED_MODE, 1: 0 = static BTFN for B-type, 1 = bimodal BHT for B-type.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- inst_i  in  32  instruction fetched at inst_addr_i.
- inst_addr_i  in  32  PC of inst_i.
- inst_valid_i  in  1  inst_i is a real instruction; when 0, prediction is forced to not-taken.
- hold_i  in  1  IF stage stalled; the instruction is not consumed and RAS state must not change.
- upd_valid_i  in  1  EX resolved a conditional branch this cycle.
- upd_pc_i  in  32  PC of the resolved branch.
- upd_taken_i  in  1  actual branch outcome.
- bp_result_o  out  1  predicted taken (`JumpEnable`/`JumpDisable`).
- bp_jump_addr_o  out  32  predicted target; `ZeroWord` when not taken.

## Operation
- Decode uses opcode = inst_i[6:0], with rd = [11:7] and rs1 = [19:15]. Targets use the codebase J/B immediate encodings added to inst_addr_i, modulo 2^32.
- `INST_JAL`:
  - always taken; target is jal_addr.
  - if rd ∈ {x1, x5}, push inst_addr_i+4 onto the RAS.
- `INST_TYPE_B`: target is b_addr.
  - PRED_MODE=0: taken iff $signed(b_addr) < $signed(inst_addr_i).
  - PRED_MODE=1: taken iff bht[idx][1]=1, where idx = inst_addr_i[2 +: log2(BHT_ENTRIES)].
- `INST_JALR` (0x67), with link = rd ∈ {x1, x5} and ret = rs1 ∈ {x1, x5}:
  - ret and not link: pop. Predict taken to the popped top if the RAS is non-empty; otherwise not taken.
  - link and not ret: push inst_addr_i+4; predict not taken.
  - link and ret with rs1≠rd: pop then push, which replaces the top. Predict taken to the old top if non-empty; if empty, push only and predict not taken.
  - link and ret with rs1=rd: push only; predict not taken.
  - neither link nor ret: not taken.
- Any other opcode: not taken, target `ZeroWord`.
- RAS side effects happen only on the accepting edge, i.e. inst_valid_i=1 and hold_i=0.
- RAS full + push: overwrite the oldest entry (circular top pointer); count saturates at RAS_DEPTH.
- RAS empty + pop: no change; count stays 0.
- BHT update (both modes maintain the table): on upd_valid_i, uidx = upd_pc_i[2 +: log2(BHT_ENTRIES)].
  - taken: counter = min(counter+1, 3).
  - not taken: counter = max(counter-1, 0).
- The RAS is not repaired on misprediction/flush. Wrong-path pushes and pops persist; this is accepted.

## Timing
- Prediction is combinational from inst_i, inst_addr_i and registered BHT/RAS state, with zero latency, in the same cycle as fetch.
- BHT update writes at the rising edge. A same-cycle lookup of the same index sees the old counter (no bypass). The next cycle sees the new value.
- RAS push/pop results are visible to the next instruction on the next cycle.
- Reset (synchronous, wins over everything, including mid-update):
  - all counters = 2'b01 (weakly not-taken);
  - RAS count = 0, top pointer = 0, entries = 0.
- Outputs during and after reset follow the combinational rules on reset state, so B-type is predicted not taken in mode 1.
- hold_i=1 for N cycles: outputs stay stable for stable inputs, and the RAS does not change. BHT updates still proceed.

## Structure
- Opcodes (`INST_JAL`, `INST_TYPE_B`, `INST_JALR`), `JumpEnable`, `JumpDisable`, `ZeroWord`, `InstBus` and `InstAddrBus` live in defines.v; add `INST_JALR` if it is absent.
- BHT counter encoding and reset value are defined as constants in defines.v.
- Sub-module bpu_ras: RAS_DEPTH-entry circular stack.
  - Inputs: push, pop, push_data.
  - Outputs: top_o, empty_o.
  - Pop-then-push is resolved internally.
- The BHT is a flop array inside bpu_dyn; it is not a RAM, because reset must clear it.

## Test plan
- Reset, then B-type at PC 0x100 with offset -16, PRED_MODE=1 → bp_result_o=0 and bp_jump_addr_o=0xF0. In PRED_MODE=0 the same instruction → taken to 0xF0.
- Two upd_valid_i taken for PC 0x100 → lookup at 0x100 is taken. The lookup in the same cycle as the second update is taken (counter goes 01→10 on the first update). Three not-taken updates → 00 (saturates), then one taken → still not taken.
- JAL x1 at 0x200, then JALR x0,0(x1) at 0x400 → JAL taken to jal_addr. JALR taken to 0x204, and the RAS is empty afterwards.
- RAS_DEPTH=4: five nested calls at 0x10, 0x20, 0x30, 0x40, 0x50, then five returns → returns target 0x54, 0x44, 0x34, 0x24. The fifth return is not taken.
- Call JAL with hold_i=1 for 3 cycles, then hold_i=0 → exactly one push. Reset asserted mid-sequence → next return is not taken.
- JALR x1,0(x5) with RAS top 0x104 → taken to 0x104; new top is inst_addr_i+4, and the count is unchanged.

Source files
------------

// File: rtl/bpu_dyn_pkg.sv
// Shared opcodes, jump encodings, BHT counter encoding and decode helpers
// for the dynamic branch prediction unit.
package bpu_dyn_pkg;

   typedef logic [31:0] inst_bus_t;
   typedef logic [31:0] inst_addr_bus_t;

   localparam logic [6:0] INST_JAL    = 7'b1101111;
   localparam logic [6:0] INST_TYPE_B = 7'b1100011;
   localparam logic [6:0] INST_JALR   = 7'b1100111;

   localparam logic           JUMP_ENABLE  = 1'b1;
   localparam logic           JUMP_DISABLE = 1'b0;
   localparam inst_addr_bus_t ZERO_WORD    = 32'h0000_0000;

   // 2-bit saturating counter; the MSB is the taken prediction.
   typedef enum logic [1:0] {
      BHT_SNT = 2'b00,
      BHT_WNT = 2'b01,
      BHT_WT  = 2'b10,
      BHT_ST  = 2'b11
   } bht_cnt_t;

   localparam bht_cnt_t BHT_RESET = BHT_WNT;

   typedef enum logic [1:0] {
      RAS_NONE,
      RAS_PUSH,
      RAS_POP,
      RAS_POP_PUSH
   } ras_op_t;

   // x1 (ra) and x5 (t0) are the link registers of the calling convention.
   function automatic logic is_link_reg(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   function automatic inst_addr_bus_t imm_j(input inst_bus_t inst);
      return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

   function automatic inst_addr_bus_t imm_b(input inst_bus_t inst);
      return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
      bht_cnt_t nxt;
      nxt = cnt;
      if (taken && cnt != BHT_ST)
         nxt = bht_cnt_t'(cnt + 2'd1);
      else if (!taken && cnt != BHT_SNT)
         nxt = bht_cnt_t'(cnt - 2'd1);
      return nxt;
   endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return-address stack. A full push overwrites the oldest entry;
// a pop on an empty stack is ignored; pop+push replaces the top in place.
module bpu_ras
   import bpu_dyn_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  logic           pop,
   input  inst_addr_bus_t push_data,
   output inst_addr_bus_t top_o,
   output logic           empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   inst_addr_bus_t   entries [DEPTH];
   logic [PTR_W-1:0] top_ptr;
   logic [PTR_W-1:0] ptr_inc;
   logic [PTR_W-1:0] ptr_dec;
   logic [CNT_W-1:0] count;

   assign ptr_inc = top_ptr + PTR_W'(1);
   assign ptr_dec = top_ptr - PTR_W'(1);
   assign top_o   = entries[top_ptr];
   assign empty_o = (count == '0);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order within the block.
   always_ff @(posedge clk) begin
      if (rst) begin
         top_ptr <= '0;
         count   <= '0;
         for (int i = 0; i < DEPTH; i++) entries[i] <= ZERO_WORD;
      end else if (push && pop && !empty_o) begin
         entries[top_ptr] <= push_data;
      end else if (push) begin
         // An empty pop+push degenerates to a plain push.
         top_ptr          <= ptr_inc;
         entries[ptr_inc] <= push_data;
         if (count != CNT_FULL) count <= count + CNT_W'(1);
      end else if (pop && !empty_o) begin
         top_ptr <= ptr_dec;
         count   <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/bpu_dyn.sv
// Dynamic branch predictor for IF: decode-based JAL/B targets, a bimodal BHT
// (or static BTFN) for conditional branches and a RAS for JALR returns.
module bpu_dyn
   import bpu_dyn_pkg::*;
#(
   parameter int BHT_ENTRIES = 64,
   parameter int RAS_DEPTH   = 4,
   parameter int PRED_MODE   = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  inst_bus_t      inst_i,
   input  inst_addr_bus_t inst_addr_i,
   input  logic           inst_valid_i,
   input  logic           hold_i,
   input  logic           upd_valid_i,
   input  inst_addr_bus_t upd_pc_i,
   input  logic           upd_taken_i,
   output logic           bp_result_o,
   output inst_addr_bus_t bp_jump_addr_o
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [6:0]       opcode;
   logic [4:0]       rd;
   logic [4:0]       rs1;
   logic             link;
   logic             ret;
   inst_addr_bus_t   jal_addr;
   inst_addr_bus_t   b_addr;
   inst_addr_bus_t   link_addr;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] uidx;
   bht_cnt_t         bht [BHT_ENTRIES];
   bht_cnt_t         lookup_cnt;
   ras_op_t          ras_op;
   logic             accept;
   logic             ras_push;
   logic             ras_pop;
   inst_addr_bus_t   ras_top;
   logic             ras_empty;
   logic             unused_upd_pc;

   assign opcode     = inst_i[6:0];
   assign rd         = inst_i[11:7];
   assign rs1        = inst_i[19:15];
   assign link       = is_link_reg(rd);
   assign ret        = is_link_reg(rs1);
   assign jal_addr   = inst_addr_i + imm_j(inst_i);
   assign b_addr     = inst_addr_i + imm_b(inst_i);
   assign link_addr  = inst_addr_i + 32'd4;
   assign idx        = inst_addr_i[2 +: IDX_W];
   assign uidx       = upd_pc_i[2 +: IDX_W];
   assign lookup_cnt = bht[idx];

   assign unused_upd_pc = ^{upd_pc_i[31:2+IDX_W], upd_pc_i[1:0]};

   // B-type always presents its decoded target; the result bit alone says
   // whether it is taken. Other not-taken cases present ZERO_WORD.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      bp_result_o    = JUMP_DISABLE;
      bp_jump_addr_o = ZERO_WORD;
      ras_op         = RAS_NONE;
      if (inst_valid_i) begin
         unique case (opcode)
            INST_JAL: begin
               bp_result_o    = JUMP_ENABLE;
               bp_jump_addr_o = jal_addr;
               if (link) ras_op = RAS_PUSH;
            end
            INST_TYPE_B: begin
               bp_jump_addr_o = b_addr;
               if (PRED_MODE == 0)
                  bp_result_o = ($signed(b_addr) < $signed(inst_addr_i));
               else
                  bp_result_o = lookup_cnt[1];
            end
            INST_JALR: begin
               if (ret && !link) begin
                  ras_op = RAS_POP;
                  if (!ras_empty) begin
                     bp_result_o    = JUMP_ENABLE;
                     bp_jump_addr_o = ras_top;
                  end
               end else if (link && ret && rs1 != rd) begin
                  ras_op = RAS_POP_PUSH;
                  if (!ras_empty) begin
                     bp_result_o    = JUMP_ENABLE;
                     bp_jump_addr_o = ras_top;
                  end
               end else if (link) begin
                  ras_op = RAS_PUSH;
               end
            end
            default: ;
         endcase
      end
   end

   assign accept   = inst_valid_i && !hold_i;
   assign ras_push = accept && (ras_op == RAS_PUSH || ras_op == RAS_POP_PUSH);
   assign ras_pop  = accept && (ras_op == RAS_POP  || ras_op == RAS_POP_PUSH);

   bpu_ras #(
      .DEPTH(RAS_DEPTH)
   ) u_ras (
      .clk      (clk),
      .rst      (rst),
      .push     (ras_push),
      .pop      (ras_pop),
      .push_data(link_addr),
      .top_o    (ras_top),
      .empty_o  (ras_empty)
   );

   // NOTE: the BHT is a flop array rather than a RAM precisely so that reset
   // can bring every counter to a known weakly-not-taken value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_RESET;
      end else if (upd_valid_i) begin
         bht[uidx] <= bht_next(bht[uidx], upd_taken_i);
      end
   end

endmodule

// File: tb/tb_bpu_dyn.sv
// Scoreboard bench for bpu_dyn: a BHT-mode and a static-mode instance share
// stimulus; expected outputs are queued by the driver and checked on negedge.
module tb_bpu_dyn;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic [31:0] inst_addr;
   logic        inst_valid;
   logic        hold;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic        res1, res0;
   logic [31:0] addr1, addr0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        r1;
      logic [31:0] a1;
      logic        r0;
      logic [31:0] a0;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   bpu_dyn #(.BHT_ENTRIES(64), .RAS_DEPTH(4), .PRED_MODE(1)) dut (
      .clk(clk), .rst(rst), .inst_i(inst), .inst_addr_i(inst_addr),
      .inst_valid_i(inst_valid), .hold_i(hold), .upd_valid_i(upd_valid),
      .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
      .bp_result_o(res1), .bp_jump_addr_o(addr1)
   );

   bpu_dyn #(.BHT_ENTRIES(64), .RAS_DEPTH(4), .PRED_MODE(0)) dut_s (
      .clk(clk), .rst(rst), .inst_i(inst), .inst_addr_i(inst_addr),
      .inst_valid_i(inst_valid), .hold_i(hold), .upd_valid_i(upd_valid),
      .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
      .bp_result_o(res0), .bp_jump_addr_o(addr0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: outputs are combinational, so any queued expectation is due
   // on the negedge of the cycle in which it was issued.
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({e.name, " bht.result"},    {31'b0, res1}, {31'b0, e.r1});
         check({e.name, " bht.target"},    addr1,         e.a1);
         check({e.name, " static.result"}, {31'b0, res0}, {31'b0, e.r0});
         check({e.name, " static.target"}, addr0,         e.a0);
      end
   end

   function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] off);
      return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] off);
      return {off[12], off[10:5], 5'd2, 5'd1, 3'b000, off[4:1], off[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'h000, rs1, 3'b000, rd, 7'h67};
   endfunction

   // One fetch cycle; rst/hold/update set by the caller last one cycle only.
   task automatic step(input logic [31:0] i, input logic [31:0] pc, input string nm,
                       input logic e1, input logic [31:0] ea1,
                       input logic e0, input logic [31:0] ea0);
      exp_t e;
      inst      = i;
      inst_addr = pc;
      e.name = nm; e.r1 = e1; e.a1 = ea1; e.r0 = e0; e.a0 = ea0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      hold       = 1'b0;
      upd_valid  = 1'b0;
      inst_valid = 1'b1;
   endtask

   task automatic stepq(input logic [31:0] i, input logic [31:0] pc, input string nm,
                        input logic e, input logic [31:0] ea);
      step(i, pc, nm, e, ea, e, ea);
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken);
      upd_valid = 1'b1;
      upd_pc    = pc;
      upd_taken = taken;
   endtask

   localparam logic [31:0] NOP = 32'h0000_0013;

   initial begin
      logic [31:0] b_m16, ret1, ret5;
      b_m16 = enc_b(32'hFFFF_FFF0);
      ret1  = enc_jalr(5'd0, 5'd1);
      ret5  = enc_jalr(5'd0, 5'd5);

      rst = 1'b1; inst = NOP; inst_addr = '0; inst_valid = 1'b1; hold = 1'b0;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
      @(posedge clk);
      #1;

      // Reset state and BTFN vs bimodal on a backward branch.
      rst = 1'b1;
      step(b_m16, 32'h100, "b_in_reset", 1'b0, 32'hF0, 1'b1, 32'hF0);
      step(b_m16, 32'h100, "b_after_reset", 1'b0, 32'hF0, 1'b1, 32'hF0);

      // Counter training at idx 0: 01 -> 10 -> 11, lookups see pre-edge value.
      upd(32'h100, 1'b1);
      step(b_m16, 32'h100, "b_upd1_same", 1'b0, 32'hF0, 1'b1, 32'hF0);
      upd(32'h100, 1'b1);
      step(b_m16, 32'h100, "b_upd2_same", 1'b1, 32'hF0, 1'b1, 32'hF0);
      step(b_m16, 32'h100, "b_strong", 1'b1, 32'hF0, 1'b1, 32'hF0);
      upd(32'h100, 1'b0);
      step(b_m16, 32'h100, "b_nt1", 1'b1, 32'hF0, 1'b1, 32'hF0);
      upd(32'h100, 1'b0);
      step(b_m16, 32'h100, "b_nt2", 1'b1, 32'hF0, 1'b1, 32'hF0);
      upd(32'h100, 1'b0);
      step(b_m16, 32'h100, "b_nt3", 1'b0, 32'hF0, 1'b1, 32'hF0);
      upd(32'h100, 1'b1);
      step(b_m16, 32'h100, "b_sat_low", 1'b0, 32'hF0, 1'b1, 32'hF0);
      step(b_m16, 32'h100, "b_after_sat", 1'b0, 32'hF0, 1'b1, 32'hF0);

      // Neighbouring index trained independently.
      upd(32'h104, 1'b1);
      step(b_m16, 32'h100, "b_idx_sep1", 1'b0, 32'hF0, 1'b1, 32'hF0);
      upd(32'h104, 1'b1);
      step(b_m16, 32'h100, "b_idx_sep2", 1'b0, 32'hF0, 1'b1, 32'hF0);
      step(b_m16, 32'h104, "b_idx1", 1'b1, 32'hF4, 1'b1, 32'hF4);
      step(enc_b(32'h20), 32'h104, "b_fwd", 1'b1, 32'h124, 1'b0, 32'h124);

      // Invalid slot and non-branch opcode.
      inst_valid = 1'b0;
      step(b_m16, 32'h104, "invalid", 1'b0, 32'h0, 1'b0, 32'h0);
      stepq(NOP, 32'h108, "nop", 1'b0, 32'h0);

      // Call / return pair.
      stepq(enc_j(5'd1, 32'h80), 32'h200, "jal_call", 1'b1, 32'h280);
      stepq(ret1, 32'h400, "jalr_ret", 1'b1, 32'h204);
      stepq(ret1, 32'h404, "jalr_ret_empty", 1'b0, 32'h0);
      stepq(enc_j(5'd0, 32'hFFFF_FFF8), 32'h40, "jal_back", 1'b1, 32'h38);

      // Five nested calls into a 4-deep stack; oldest return address is lost.
      for (int k = 1; k <= 5; k++)
         stepq(enc_j(5'd1, 32'h100), 32'(k * 16), "nest_call", 1'b1, 32'(k * 16 + 256));
      stepq(ret1, 32'h300, "nest_ret1", 1'b1, 32'h54);
      stepq(ret1, 32'h300, "nest_ret2", 1'b1, 32'h44);
      stepq(ret1, 32'h300, "nest_ret3", 1'b1, 32'h34);
      stepq(ret1, 32'h300, "nest_ret4", 1'b1, 32'h24);
      stepq(ret1, 32'h300, "nest_ret5", 1'b0, 32'h0);

      // Held call pushes exactly once.
      for (int k = 0; k < 3; k++) begin
         hold = 1'b1;
         stepq(enc_j(5'd1, 32'h40), 32'h600, "hold_call", 1'b1, 32'h640);
      end
      stepq(enc_j(5'd1, 32'h40), 32'h600, "release_call", 1'b1, 32'h640);
      stepq(ret5, 32'h700, "hold_ret", 1'b1, 32'h604);
      stepq(ret5, 32'h700, "hold_ret_empty", 1'b0, 32'h0);

      // Reset wins over a concurrent BHT update and clears the RAS.
      stepq(enc_j(5'd1, 32'h40), 32'h800, "pre_rst_call", 1'b1, 32'h840);
      rst = 1'b1;
      upd(32'h108, 1'b1);
      stepq(NOP, 32'h804, "rst_mid", 1'b0, 32'h0);
      step(b_m16, 32'h108, "b_rst_over_upd", 1'b0, 32'hF8, 1'b1, 32'hF8);
      step(b_m16, 32'h104, "b_rst_cleared", 1'b0, 32'hF4, 1'b1, 32'hF4);
      stepq(ret1, 32'h300, "ret_after_rst", 1'b0, 32'h0);

      // Coroutine-style JALR variants.
      stepq(enc_j(5'd1, 32'h40), 32'h100, "co_call", 1'b1, 32'h140);
      stepq(enc_jalr(5'd1, 5'd5), 32'h900, "co_swap", 1'b1, 32'h104);
      stepq(ret1, 32'hA00, "co_ret_new_top", 1'b1, 32'h904);
      stepq(ret1, 32'hA04, "co_ret_empty", 1'b0, 32'h0);
      stepq(enc_jalr(5'd1, 5'd1), 32'hB00, "same_reg_push", 1'b0, 32'h0);
      stepq(ret5, 32'hB40, "same_reg_ret", 1'b1, 32'hB04);
      stepq(enc_jalr(5'd1, 5'd5), 32'hC00, "swap_empty_push", 1'b0, 32'h0);
      stepq(ret1, 32'hD00, "swap_empty_ret", 1'b1, 32'hC04);
      stepq(enc_jalr(5'd0, 5'd2), 32'hE00, "jalr_plain", 1'b0, 32'h0);
      stepq(ret1, 32'hE04, "final_empty", 1'b0, 32'h0);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
